// File: rtl/pes_cc_decomp_if.sv
// Line-in / line-out handshake bundle for the base-delta line decompressor.
interface pes_cc_decomp_if;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_enc;
   logic [255:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] out_data;
   logic         out_enc_err;

   modport master (
      output in_valid, in_enc, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_enc_err
   );

   modport slave (
      input  in_valid, in_enc, in_data, out_ready,
      output in_ready, out_valid, out_data, out_enc_err
   );
endinterface

// File: rtl/pes_cc_decomp.sv
// Base-delta line decompressor: expands one lane per clock into a 256-bit line.
// Optional macro PES_CC_DECOMP_ZERO_EN makes encoding 7 a legal all-zero line.
module pes_cc_decomp (
   input  logic               clock,
   input  logic               reset,
   pes_cc_decomp_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t        state_q;
   logic [2:0]    enc_q;
   logic [255:0]  data_q;
   logic [255:0]  out_data_q;
   logic          out_valid_q;
   logic          out_enc_err_q;
   logic [3:0]    idx_q;

   // 64-bit base lanes; dsz selects 1, 2 or 4 byte deltas.
   function automatic logic [63:0] lane_b8(input logic [255:0] d, input logic [1:0] i,
                                           input logic [1:0] dsz);
      logic [7:0]  off;
      logic [63:0] delta;
      case (dsz)
         2'd0: begin
            off   = 8'd64 + {3'b000, i, 3'b000};
            delta = {{56{d[off + 8'd7]}}, d[off +: 8]};
         end
         2'd1: begin
            off   = 8'd64 + {2'b00, i, 4'b0000};
            delta = {{48{d[off + 8'd15]}}, d[off +: 16]};
         end
         default: begin
            off   = 8'd64 + {1'b0, i, 5'b00000};
            delta = {{32{d[off + 8'd31]}}, d[off +: 32]};
         end
      endcase
      return d[63:0] + delta;
   endfunction

   function automatic logic [31:0] lane_b4(input logic [255:0] d, input logic [2:0] i,
                                           input logic d2);
      logic [7:0]  off;
      logic [31:0] delta;
      if (d2) begin
         off   = 8'd32 + {1'b0, i, 4'b0000};
         delta = {{16{d[off + 8'd15]}}, d[off +: 16]};
      end else begin
         off   = 8'd32 + {2'b00, i, 3'b000};
         delta = {{24{d[off + 8'd7]}}, d[off +: 8]};
      end
      return d[31:0] + delta;
   endfunction

   function automatic logic [15:0] lane_b2(input logic [255:0] d, input logic [3:0] i);
      logic [7:0]  off;
      logic [15:0] delta;
      off   = 8'd16 + {1'b0, i, 3'b000};
      delta = {{8{d[off + 8'd7]}}, d[off +: 8]};
      return d[15:0] + delta;
   endfunction

   // Line FSM: capture, per-lane expansion, and output hold until consumed.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         enc_q         <= 3'd0;
         data_q        <= 256'd0;
         out_data_q    <= 256'd0;
         out_valid_q   <= 1'b0;
         out_enc_err_q <= 1'b0;
         idx_q         <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  enc_q         <= bus.in_enc;
                  data_q        <= bus.in_data;
                  out_data_q    <= 256'd0;
                  out_enc_err_q <= 1'b0;
                  idx_q         <= 4'd0;
                  state_q       <= EXPAND;
               end else begin
                  state_q <= IDLE;
               end
            end
            EXPAND: begin
               case (enc_q)
                  3'd0: begin
                     out_data_q  <= data_q;
                     out_valid_q <= 1'b1;
                     state_q     <= HOLD;
                  end
                  3'd1, 3'd2, 3'd3: begin
                     out_data_q[{idx_q[1:0], 6'b000000} +: 64] <=
                        lane_b8(data_q, idx_q[1:0], enc_q[1:0] - 2'd1);
                     idx_q <= idx_q + 4'd1;
                     if (idx_q[1:0] == 2'd3) begin
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                     end else begin
                        state_q <= EXPAND;
                     end
                  end
                  3'd4, 3'd5: begin
                     out_data_q[{idx_q[2:0], 5'b00000} +: 32] <=
                        lane_b4(data_q, idx_q[2:0], enc_q[0]);
                     idx_q <= idx_q + 4'd1;
                     if (idx_q[2:0] == 3'd7) begin
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                     end else begin
                        state_q <= EXPAND;
                     end
                  end
                  3'd6: begin
                     out_data_q[{idx_q, 4'b0000} +: 16] <= lane_b2(data_q, idx_q);
                     idx_q <= idx_q + 4'd1;
                     if (idx_q == 4'd15) begin
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                     end else begin
                        state_q <= EXPAND;
                     end
                  end
                  default: begin
                     // Zero line: legal only when the optional feature is built in.
                     out_data_q  <= 256'd0;
`ifdef PES_CC_DECOMP_ZERO_EN
                     out_enc_err_q <= 1'b0;
`else
                     out_enc_err_q <= 1'b1;
`endif
                     out_valid_q <= 1'b1;
                     state_q     <= HOLD;
                  end
               endcase
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  state_q <= HOLD;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   // Ready drops in the same cycle reset is raised and returns as soon as it falls.
   assign bus.in_ready    = (state_q == IDLE) && !reset;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_enc_err = out_enc_err_q;

endmodule

// File: tb/tb_pes_cc_decomp.sv
// Self-checking bench for pes_cc_decomp against an arithmetic line model.
module tb_pes_cc_decomp;
   logic clock = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [255:0] last_out;

   pes_cc_decomp_if bus();

   pes_cc_decomp dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] model_line(input logic [2:0] enc, input logic [255:0] d);
      int bw, dw, n;
      logic [255:0] r, bmask, dmask, base, delta, lane;
      case (enc)
         3'd0: return d;
         3'd1: begin bw = 8; dw = 1; end
         3'd2: begin bw = 8; dw = 2; end
         3'd3: begin bw = 8; dw = 4; end
         3'd4: begin bw = 4; dw = 1; end
         3'd5: begin bw = 4; dw = 2; end
         3'd6: begin bw = 2; dw = 1; end
         default: return 256'd0;
      endcase
      n     = 32 / bw;
      bmask = (256'd1 << (bw*8)) - 256'd1;
      dmask = (256'd1 << (dw*8)) - 256'd1;
      base  = d & bmask;
      r     = 256'd0;
      for (int i = 0; i < n; i++) begin
         delta = (d >> (bw*8 + i*dw*8)) & dmask;
         if (delta[dw*8-1]) delta = delta | ~dmask;
         lane = (base + delta) & bmask;
         r    = r | (lane << (i*bw*8));
      end
      return r;
   endfunction

   function automatic int model_lat(input logic [2:0] enc);
      case (enc)
         3'd1, 3'd2, 3'd3: return 4;
         3'd4, 3'd5:       return 8;
         3'd6:             return 16;
         default:          return 1;
      endcase
   endfunction

   function automatic logic model_err(input logic [2:0] enc);
`ifdef PES_CC_DECOMP_ZERO_EN
      return 1'b0;
`else
      return (enc == 3'd7);
`endif
   endfunction

   // Send one line, scramble inputs after acceptance, check latency/data/error, then drain.
   task automatic do_line(input logic [2:0] enc, input logic [255:0] d, input string tag);
      logic [255:0] exp_d;
      int   exp_n, edges;
      logic exp_e, rdy_bad;
      exp_d   = model_line(enc, d);
      exp_n   = model_lat(enc);
      exp_e   = model_err(enc);
      rdy_bad = 1'b0;
      @(negedge clock);
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready_idle: got %b want 1", tag, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_enc   = enc;
      bus.in_data  = d;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      bus.in_enc   = 3'($urandom);
      bus.in_data  = rand256();
      edges = 0;
      while (bus.out_valid !== 1'b1 && edges < 40) begin
         if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
         @(posedge clock); #1;
         edges++;
      end
      if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
      last_out = bus.out_data;
      n_tests++;
      if (edges != exp_n) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", tag, edges, exp_n);
      end
      n_tests++;
      if (bus.out_data !== exp_d) begin
         n_fail++;
         $display("FAIL %s data: got %h want %h", tag, bus.out_data, exp_d);
      end
      n_tests++;
      if (bus.out_enc_err !== exp_e) begin
         n_fail++;
         $display("FAIL %s enc_err: got %b want %b", tag, bus.out_enc_err, exp_e);
      end
      n_tests++;
      if (rdy_bad) begin
         n_fail++;
         $display("FAIL %s in_ready_busy: got 1 want 0", tag);
      end
      @(negedge clock);
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s release: got valid=%b ready=%b want valid=0 ready=1",
                  tag, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_enc    = 3'd0;
      bus.in_data   = 256'd0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.out_data !== 256'd0 || bus.out_enc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got ready=%b valid=%b err=%b data=%h want 0/0/0/0",
                  bus.in_ready, bus.out_valid, bus.out_enc_err, bus.out_data);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_vectors();
      logic [255:0] d;
      d = {160'd0, 8'h66, 8'h44, 8'h22, 8'h00, 64'h0};
      do_line(3'd1, d, "b8d1_vec");
      n_tests++;
      if (last_out !== {64'h66, 64'h44, 64'h22, 64'h0}) begin
         n_fail++;
         $display("FAIL b8d1_const: got %h", last_out);
      end
      d = {160'd0, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h00, 32'h0};
      do_line(3'd4, d, "b4d1_vec");
      d = {112'd0, 8'h85, 8'h80, 8'h75, 8'h70, 8'h65, 8'h60, 8'h55, 8'h50,
           8'h40, 8'h35, 8'h30, 8'h25, 8'h20, 8'h15, 8'h10, 8'h00, 16'h0};
      do_line(3'd6, d, "b2d1_vec");
      d = {128'd0, 16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 64'h1000};
      do_line(3'd2, d, "b8d2_signed");
      n_tests++;
      if (last_out[127:0] !== {64'h1001, 64'h0FFF}) begin
         n_fail++;
         $display("FAIL b8d2_const: got %h want %h", last_out[127:0], {64'h1001, 64'h0FFF});
      end
      do_line(3'd7, rand256(), "zero_line");
      do_line(3'd0, rand256(), "raw");
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         do_line(3'($urandom_range(0, 7)), rand256(), "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] d, exp_d, snap;
      int   edges;
      logic bad;
      d     = rand256();
      exp_d = model_line(3'd3, d);
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_enc   = 3'd3;
      bus.in_data  = d;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      @(negedge clock);
      bus.out_ready = 1'b1;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      bus.out_ready = 1'b0;
      edges = 2;
      while (bus.out_valid !== 1'b1 && edges < 40) begin
         @(posedge clock); #1;
         edges++;
      end
      n_tests++;
      if (edges != 4 || bus.out_data !== exp_d) begin
         n_fail++;
         $display("FAIL bp_ignored_ready: got edges=%0d data=%h want 4 %h", edges, bus.out_data, exp_d);
      end
      snap = bus.out_data;
      bad  = 1'b0;
      repeat (5) begin
         @(negedge clock);
         if (bus.out_data !== snap || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL bp_hold: got unstable hold want stable data, ready=0, valid=1");
      end
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
      end
      do_line(3'd5, rand256(), "bp_next");
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_enc   = 3'd6;
      bus.in_data  = rand256();
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 256'd0 ||
          bus.out_enc_err !== 1'b0 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got valid=%b err=%b ready=%b data=%h want 0/0/0/0",
                  bus.out_valid, bus.out_enc_err, bus.in_ready, bus.out_data);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_ready: got %b want 1", bus.in_ready);
      end
      do_line(3'd0, rand256(), "after_reset");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
